uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, frame constants
// and the even-parity helper.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } uart_state_t;

   // Even parity: the parity bit makes the total count of ones even.
   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle
// (high) level so reset never looks like a start bit.
module uart_rx_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, one stop bit, single-entry output
// register with valid/ack. Define UART_RX_PARITY_EN for an even-parity bit.
//
// Output handshake: o_valid/o_data form a one-deep holding register. o_valid
// stays high with o_data stable until a cycle where i_ack is high; it drops on
// the following cycle unless a new byte lands in that same cycle. A byte that
// arrives while o_valid is high and i_ack is low is dropped (o_overrun).
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_rx,
   input  logic       i_ack,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_frame_err,
   output logic       o_overrun,
   output logic       o_parity_err,
   output logic [2:0] o_state
);

   localparam logic [9:0] BIT_LAST  = 10'(CLKS_PER_BIT - 1);
   localparam logic [9:0] HALF_LAST = 10'(CLKS_PER_BIT / 2 - 1);

   uart_state_t          state;
   logic                 rx_s;
   logic                 rx_prev;
   logic [9:0]           cnt;
   logic [2:0]           bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bad;

   uart_rx_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (i_rx),
      .q     (rx_s)
   );

   assign o_state = state;

`ifndef UART_RX_PARITY_EN
   assign par_bad      = 1'b0;
   assign o_parity_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         rx_prev     <= 1'b1;
         cnt         <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         o_data      <= 8'h00;
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad      <= 1'b0;
         o_parity_err <= 1'b0;
`endif
      end else begin
         rx_prev     <= rx_s;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         o_parity_err <= 1'b0;
`endif
         // A delivery later in this block overrides this clear.
         if (o_valid && i_ack)
            o_valid <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (rx_prev && !rx_s) begin
                  state   <= ST_START;
                  cnt     <= '0;
                  bit_cnt <= '0;
               end
            end
            ST_START: begin
               if (cnt == HALF_LAST) begin
                  cnt   <= '0;
                  state <= rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  cnt <= cnt + 10'd1;
               end
            end
            ST_DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt     <= '0;
                  shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                     state <= ST_PARITY;
`else
                     state <= ST_STOP;
`endif
                  end
               end else begin
                  cnt <= cnt + 10'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (cnt == BIT_LAST) begin
                  cnt          <= '0;
                  par_bad      <= (rx_s != even_parity(shreg));
                  o_parity_err <= (rx_s != even_parity(shreg));
                  state        <= ST_STOP;
               end else begin
                  cnt <= cnt + 10'd1;
               end
            end
`endif
            ST_STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt <= '0;
                  if (rx_s) begin
                     state <= ST_IDLE;
                     if (!par_bad) begin
                        if (!o_valid || i_ack) begin
                           o_data  <= shreg;
                           o_valid <= 1'b1;
                        end else begin
                           o_overrun <= 1'b1;
                        end
                     end
                  end else begin
                     o_frame_err <= 1'b1;
                     state       <= ST_BREAK;
                  end
               end else begin
                  cnt <= cnt + 10'd1;
               end
            end
            ST_BREAK: begin
               if (rx_s)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames, an event-queue model of the
// output register, per-cycle compare plus literal spot checks.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS = 9;
`else
   localparam int NBITS = 8;
`endif
   // Line edge -> stop-sample edge: 2 sync flops, 1 edge detect, half a bit,
   // then one full bit per data/parity bit and one for the stop bit.
   localparam int LAT = 3 + HALF + NBITS * CPB + CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_rx = 1'b1;
   logic       i_ack = 1'b0;
   logic [7:0] o_data;
   logic       o_valid, o_frame_err, o_overrun, o_parity_err;
   logic [2:0] o_state;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk          (clk),
      .reset        (rst),
      .i_rx         (i_rx),
      .i_ack        (i_ack),
      .o_data       (o_data),
      .o_valid      (o_valid),
      .o_frame_err  (o_frame_err),
      .o_overrun    (o_overrun),
      .o_parity_err (o_parity_err),
      .o_state      (o_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- model ----------------
   int         cyc = 0;
   int         ack_cyc = -10;
   int         ev_cyc_q[$];
   int         ev_kind_q[$];     // 0 byte complete, 1 frame error, 2 parity error
   logic [7:0] exp_q[$];
   logic [7:0] m_data = 8'h00;
   logic       m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;
   logic       ev_deliver;
   logic [7:0] ev_byte;

   always @(posedge clk) begin
      cyc = cyc + 1;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      m_perr = 1'b0;
      if (rst) begin
         m_valid = 1'b0;
         m_data  = 8'h00;
         ev_cyc_q.delete();
         ev_kind_q.delete();
         exp_q.delete();
      end else begin
         ev_deliver = 1'b0;
         ev_byte    = 8'h00;
         while (ev_cyc_q.size() > 0 && ev_cyc_q[0] == cyc) begin
            case (ev_kind_q[0])
               0: begin ev_deliver = 1'b1; ev_byte = exp_q[0]; end
               1: m_ferr = 1'b1;
               default: m_perr = 1'b1;
            endcase
            void'(ev_cyc_q.pop_front());
            void'(ev_kind_q.pop_front());
            void'(exp_q.pop_front());
         end
         if (ev_deliver) begin
            if (!m_valid || i_ack) begin
               m_data  = ev_byte;
               m_valid = 1'b1;
            end else begin
               m_ovr = 1'b1;
            end
         end else if (m_valid && i_ack) begin
            m_valid = 1'b0;
         end
      end
   end

   // i_ack is high exactly across the edge at which cyc becomes ack_cyc.
   always @(posedge clk) begin
      #1;
      i_ack = (cyc == ack_cyc - 1);
   end

   // ---------------- scoreboard ----------------
   int   n_checks = 0;
   int   n_pass = 0;
   int   ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0;
   logic lit_res_q[$];

   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   always @(negedge clk) begin
      while (lit_res_q.size() > 0) begin
         n_checks++;
         if (lit_res_q.pop_front()) n_pass++;
      end
      if (o_frame_err === 1'b1) ferr_cnt++;
      if (o_overrun === 1'b1) ovr_cnt++;
      if (o_parity_err === 1'b1) perr_cnt++;
      if (!rst) begin
         cmp("valid", {7'd0, o_valid}, {7'd0, m_valid});
         cmp("data", o_data, m_data);
         cmp("frame_err", {7'd0, o_frame_err}, {7'd0, m_ferr});
         cmp("overrun", {7'd0, o_overrun}, {7'd0, m_ovr});
         cmp("parity_err", {7'd0, o_parity_err}, {7'd0, m_perr});
      end
   end

   task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
      if (act !== exp) $display("FAIL lit_%s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      lit_res_q.push_back(act === exp);
   endtask

   // ---------------- driver tasks ----------------
   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ack_in(input int n);
      ack_cyc = cyc + n;
      wait_cycles(n + 2);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_ok,
                             input bit abort_d3, input bit ack_on_deliver);
      int c0;
      @(posedge clk);
      #1;
      i_rx = 1'b0;
      c0 = cyc;
      if (!abort_d3) begin
`ifdef UART_RX_PARITY_EN
         if (!par_ok) begin
            ev_cyc_q.push_back(c0 + LAT - CPB); ev_kind_q.push_back(2); exp_q.push_back(8'h00);
         end
`endif
         if (!stop_bit) begin
            ev_cyc_q.push_back(c0 + LAT); ev_kind_q.push_back(1); exp_q.push_back(8'h00);
         end else if (par_ok) begin
            ev_cyc_q.push_back(c0 + LAT); ev_kind_q.push_back(0); exp_q.push_back(d);
         end
      end
      if (ack_on_deliver) ack_cyc = c0 + LAT;
      for (int i = 0; i < 8; i++) begin
         wait_cycles(CPB);
         i_rx = d[i];
         if (abort_d3 && i == 3) begin
            wait_cycles(4);
            rst = 1'b1;
            wait_cycles(2);
            rst = 1'b0;
         end
      end
`ifdef UART_RX_PARITY_EN
      wait_cycles(CPB);
      i_rx = par_ok ? ^d : ~(^d);
`endif
      wait_cycles(CPB);
      i_rx = stop_bit;
      wait_cycles(CPB);
   endtask

   // ---------------- stimulus ----------------
   logic [7:0] table_bytes [4] = '{8'h00, 8'hFF, 8'h55, 8'h81};

   initial begin
      rst  = 1'b1;
      i_rx = 1'b1;
      wait_cycles(3);
      settle();
      lit("rst_valid", {7'd0, o_valid}, 8'h00);
      lit("rst_data", o_data, 8'h00);
      lit("rst_state", {5'd0, o_state}, 8'(ST_IDLE));
      lit("rst_errs", {5'd0, o_frame_err, o_overrun, o_parity_err}, 8'h00);
      wait_cycles(1);
      rst = 1'b0;
      wait_cycles(5);

      // Basic frame, held until acknowledged.
      send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
      wait_cycles(20);
      settle();
      lit("a5_data", o_data, 8'hA5);
      lit("a5_held", {7'd0, o_valid}, 8'h01);
      ack_in(2);
      settle();
      lit("a5_acked", {7'd0, o_valid}, 8'h00);
      lit("a5_kept", o_data, 8'hA5);

      // Start-bit glitch is rejected.
      i_rx = 1'b0;
      wait_cycles(4);
      i_rx = 1'b1;
      wait_cycles(20);
      settle();
      lit("glitch_state", {5'd0, o_state}, 8'(ST_IDLE));
      lit("glitch_valid", {7'd0, o_valid}, 8'h00);
      send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
      settle();
      lit("3c_data", o_data, 8'h3C);
      ack_in(3);

      // Framing error with the line held low (break).
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
      wait_cycles(10);
      settle();
      lit("break_state", {5'd0, o_state}, 8'(ST_BREAK));
      wait_cycles(40 - CPB - 10);
      i_rx = 1'b1;
      wait_cycles(10);
      settle();
      lit("ferr_once", 8'(ferr_cnt), 8'd1);
      lit("ferr_novalid", {7'd0, o_valid}, 8'h00);
      send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
      settle();
      lit("01_data", o_data, 8'h01);
      ack_in(2);

      // Ack with nothing pending is ignored.
      ack_in(2);
      settle();
      lit("idle_ack", {7'd0, o_valid}, 8'h00);

      // Overrun, then same-cycle ack and delivery.
      send_frame(8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
      send_frame(8'h22, 1'b1, 1'b1, 1'b0, 1'b0);
      settle();
      lit("ovr_once", 8'(ovr_cnt), 8'd1);
      lit("ovr_keep", o_data, 8'h11);
      ack_in(2);
      send_frame(8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
      send_frame(8'h22, 1'b1, 1'b1, 1'b0, 1'b1);
      settle();
      lit("ackdel_data", o_data, 8'h22);
      lit("ackdel_valid", {7'd0, o_valid}, 8'h01);
      lit("ackdel_noovr", 8'(ovr_cnt), 8'd1);
      ack_in(2);

      // Reset in the middle of a frame.
      send_frame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
      wait_cycles(20);
      settle();
      lit("abort_valid", {7'd0, o_valid}, 8'h00);
      send_frame(8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
      settle();
      lit("80_data", o_data, 8'h80);
      ack_in(2);

      // A few more bytes, each acknowledged.
      for (int i = 0; i < 4; i++) begin
         send_frame(table_bytes[i], 1'b1, 1'b1, 1'b0, 1'b0);
         ack_in(2);
      end

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
      settle();
      lit("perr_once", 8'(perr_cnt), 8'd1);
      lit("perr_novalid", {7'd0, o_valid}, 8'h00);
      send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
      settle();
      lit("07_data", o_data, 8'h07);
      ack_in(2);
`endif

      wait_cycles(5);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule
